// File: rtl/dtree_pkg.sv
// dtree_pkg: FSM encoding, node-word field layout helpers and leaf-class extraction.
package dtree_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WALK = 2'd1;
  localparam state_t S_DONE = 2'd2;
  localparam int SHIFT_W = 3;
  function automatic int fi_w(input int n_feat);
    return (n_feat > 1) ? $clog2(n_feat) : 1;
  endfunction
  function automatic int right_lsb();
    return 0;
  endfunction
  function automatic int left_lsb(input int na_w);
    return na_w;
  endfunction
  function automatic int thr_lsb(input int na_w);
    return 2 * na_w;
  endfunction
  function automatic int shift_lsb(input int feat_w, input int na_w);
    return 2 * na_w + feat_w;
  endfunction
  function automatic int fi_lsb(input int feat_w, input int na_w);
    return shift_lsb(feat_w, na_w) + SHIFT_W;
  endfunction
  function automatic int leaf_bit(input int n_feat, input int feat_w, input int na_w);
    return fi_lsb(feat_w, na_w) + fi_w(n_feat);
  endfunction
  function automatic int node_w(input int n_feat, input int feat_w, input int na_w);
    return leaf_bit(n_feat, feat_w, na_w) + 1;
  endfunction
  localparam int NODE_W = node_w(7, 8, 5);
  // A leaf reuses the left/right child fields to carry its class in the low bits.
  function automatic logic [31:0] leaf_class(input logic [63:0] node, input int class_w);
    return node[31:0] & ((32'd1 << class_w) - 32'd1);
  endfunction
endpackage

// File: rtl/dtree_node_eval.sv
// dtree_node_eval: combinational evaluation of one node word against a feature vector.
module dtree_node_eval
  import dtree_pkg::*;
#(
  parameter int N_FEAT  = 7,
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 5,
  parameter int NA_W    = 5,
  localparam int FI_W   = fi_w(N_FEAT),
  localparam int NODE_W_L = node_w(N_FEAT, FEAT_W, NA_W)
) (
  input  logic [NODE_W_L-1:0]      node_i,
  input  logic [N_FEAT*FEAT_W-1:0] feat_i,
  output logic                     leaf_o,
  output logic [NA_W-1:0]          next_o,
  output logic [CLASS_W-1:0]       class_o
);
  logic [FI_W-1:0]    fidx;
  logic [SHIFT_W-1:0] sh;
  logic [FEAT_W-1:0]  thr;
  logic [FEAT_W-1:0]  f;
  logic [NA_W-1:0]    left;
  logic [NA_W-1:0]    right;
  assign leaf_o = node_i[leaf_bit(N_FEAT, FEAT_W, NA_W)];
  assign fidx   = node_i[fi_lsb(FEAT_W, NA_W) +: FI_W];
  assign sh     = node_i[shift_lsb(FEAT_W, NA_W) +: SHIFT_W];
  assign thr    = node_i[thr_lsb(NA_W) +: FEAT_W];
  assign left   = node_i[left_lsb(NA_W) +: NA_W];
  assign right  = node_i[right_lsb() +: NA_W];
  // Out-of-range feature indices fall back to feature 0.
  assign f = ({1'b0, fidx} < (FI_W+1)'(N_FEAT)) ? feat_i[fidx*FEAT_W +: FEAT_W] : feat_i[FEAT_W-1:0];
  assign next_o  = ((f >> sh) <= thr) ? left : right;
  assign class_o = CLASS_W'(leaf_class(64'(node_i), CLASS_W));
endmodule

// File: rtl/dtree_seq_engine.sv
// dtree_seq_engine: runtime-programmable decision tree walking one node per cycle.
module dtree_seq_engine
  import dtree_pkg::*;
#(
  parameter int N_FEAT        = 7,
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 5,
  parameter int N_NODES       = 32,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_CLASS = 0,
  localparam int NA_W         = $clog2(N_NODES),
  localparam int NODE_W_L     = node_w(N_FEAT, FEAT_W, NA_W),
  localparam int DW           = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NA_W-1:0]          cfg_addr,
  input  logic [NODE_W_L-1:0]      cfg_wdata,
  output logic                     busy
);
  state_t                    state_q, state_d;
  logic [NA_W-1:0]           cur_q, cur_d;
  logic [DW-1:0]             depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0]  feat_q, feat_d;
  logic [CLASS_W-1:0]        class_q, class_d;
  logic                      err_q, err_d;
  logic [NODE_W_L-1:0]       tbl_q [N_NODES];
  logic                      ev_leaf;
  logic [NA_W-1:0]           ev_next;
  logic [CLASS_W-1:0]        ev_class;

  dtree_node_eval #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .CLASS_W(CLASS_W),
    .NA_W   (NA_W)
  ) u_eval (
    .node_i (tbl_q[cur_q]),
    .feat_i (feat_q),
    .leaf_o (ev_leaf),
    .next_o (ev_next),
    .class_o(ev_class)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_class = class_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    if (state_q == S_IDLE) begin
      if (in_valid) begin
        feat_d  = in_feat;
        cur_d   = '0;
        depth_d = '0;
        state_d = S_WALK;
      end
    end else if (state_q == S_WALK) begin
      if (ev_leaf) begin
        class_d = ev_class;
        err_d   = 1'b0;
        state_d = S_DONE;
      end else if (depth_q == DW'(MAX_DEPTH - 1)) begin
        class_d = CLASS_W'(DEFAULT_CLASS);
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        cur_d   = ev_next;
        depth_d = depth_q + DW'(1);
      end
    end else begin
      state_d = out_ready ? S_IDLE : S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Writes while busy are dropped so an in-flight walk sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) tbl_q[i] <= '0;
    end else if (cfg_we && state_q == S_IDLE) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end
endmodule

// File: tb/tb_dtree_seq_engine.sv
// tb_dtree_seq_engine: directed vectors with hand-computed classes and latencies.
module tb_dtree_seq_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [55:0] in_feat = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_class;
  logic        out_err;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [24:0] cfg_wdata = '0;
  logic        busy;
  int          n_chk = 0;
  int          n_pass = 0;

  dtree_seq_engine dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_feat  (in_feat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_err  (out_err),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [24:0] nd(input logic lf, input logic [2:0] fi, input logic [2:0] sh,
                                     input logic [7:0] th, input logic [4:0] l, input logic [4:0] r);
    return {lf, fi, sh, th, l, r};
  endfunction

  function automatic logic [24:0] lf(input logic [4:0] c);
    return nd(1'b1, 3'd0, 3'd0, 8'd0, 5'd0, c);
  endfunction

  task automatic wr(input logic [4:0] a, input logic [24:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run(input string tag, input logic [55:0] f, input int exp_c, input int exp_e,
                     input int exp_lat, input int hold, input logic busy_wr);
    int n;
    in_valid = 1'b1;
    in_feat = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we = busy_wr;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      n++;
    end
    cfg_we = 1'b0;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_class"}, out_class, exp_c);
    chk({tag, "_err"}, out_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_class"}, out_class, exp_c);
      chk({tag, "_hold_inready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_inready"}, in_ready, 1);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("unprog", 56'h0123_4567_89AB_CD, 0, 1, 8, 0, 1'b0);
    wr(5'd0, lf(5'd5));
    run("rootleaf", 56'h0, 5, 0, 1, 0, 1'b0);
    wr(5'd1, lf(5'd25));
    wr(5'd2, lf(5'd11));
    wr(5'd0, nd(1'b0, 3'd6, 3'd5, 8'd0, 5'd1, 5'd2));
    run("f6_1f", 56'h1F_0000_0000_0000, 25, 0, 2, 0, 1'b0);
    run("f6_20", 56'h20_0000_0000_0000, 11, 0, 2, 0, 1'b0);
    cfg_addr = 5'd1;
    cfg_wdata = lf(5'd7);
    run("busywr", 56'h1F_0000_0000_0000, 25, 0, 2, 0, 1'b1);
    run("after_busywr", 56'h1F_0000_0000_0000, 25, 0, 2, 0, 1'b0);
    wr(5'd0, nd(1'b0, 3'd7, 3'd0, 8'h10, 5'd1, 5'd2));
    run("fidx7_le", 56'hFF_0000_0000_0010, 25, 0, 2, 0, 1'b0);
    run("fidx7_gt", 56'h00_0000_0000_0011, 11, 0, 2, 0, 1'b0);
    wr(5'd0, nd(1'b0, 3'd0, 3'd0, 8'hFF, 5'd3, 5'd3));
    wr(5'd3, nd(1'b0, 3'd1, 3'd0, 8'hFF, 5'd4, 5'd4));
    wr(5'd4, nd(1'b0, 3'd2, 3'd0, 8'hFF, 5'd5, 5'd5));
    wr(5'd5, nd(1'b0, 3'd3, 3'd0, 8'hFF, 5'd6, 5'd6));
    wr(5'd6, lf(5'd19));
    run("chain", 56'h11_2233_4455_6677, 19, 0, 5, 3, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("after_rst", 56'h0, 0, 1, 8, 0, 1'b0);
    cfg_we = 1'b1;
    cfg_addr = 5'd0;
    cfg_wdata = lf(5'd9);
    run("samecycle", 56'h0, 9, 0, 1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
endmodule
